// File: rtl/gsn_mac_acc.sv
// Gaussian-blur tap accumulator: sums NUM_TAPS signed products per pixel, then
// rounds, normalises by 2^SHIFT and clamps to an 8-bit pixel with a ready/valid output.
module gsn_mac_acc #(
   parameter int NUM_TAPS = 25,
   parameter int SHIFT    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        in_valid,
   input  logic [21:0] prod,
   output logic        in_ready,
   output logic [7:0]  pix_out,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [15:0] sat_cnt
);
   localparam int CNT_W = $clog2(NUM_TAPS);
   localparam int ACC_W = 22 + CNT_W;
   localparam logic [CNT_W-1:0]      LAST    = CNT_W'(NUM_TAPS - 1);
   localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W + 1)'(255);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] prod_x;
   logic signed [ACC_W-1:0] total;
   logic signed [ACC_W:0]   rnd;
   logic signed [ACC_W:0]   r;
   logic [CNT_W-1:0]        cnt;
   logic                    last_tap;
   logic                    xfer;
   logic                    fin;
   logic                    drain;
   logic                    clip;
   logic [7:0]              pix_nxt;

   // Rounding runs one bit wider than the accumulator so +HALF can never wrap.
   always_comb begin
      prod_x  = {{(ACC_W - 22){prod[21]}}, prod};
      total   = acc + prod_x;
      rnd     = {total[ACC_W-1], total} + HALF;
      r       = rnd >>> SHIFT;
      clip    = r[ACC_W] || (r > PIX_MAX);
      pix_nxt = r[ACC_W] ? 8'd0 : ((r > PIX_MAX) ? 8'hFF : r[7:0]);
   end

   assign last_tap = (cnt == LAST);
   assign in_ready = ce && (!last_tap || !pix_valid || pix_ready);
   assign xfer     = in_ready && in_valid;
   assign fin      = xfer && last_tap;
   assign drain    = ce && pix_valid && pix_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         pix_out   <= '0;
         pix_valid <= 1'b0;
         sat_cnt   <= '0;
      end else if (ce) begin
         if (xfer) begin
            acc <= (cnt == '0) ? prod_x : total;
            cnt <= last_tap ? '0 : cnt + CNT_W'(1);
         end
         // A new pixel overrides the drain so back-to-back frames keep pix_valid high.
         if (fin) begin
            pix_out   <= pix_nxt;
            pix_valid <= 1'b1;
            if (clip && sat_cnt != 16'hFFFF)
               sat_cnt <= sat_cnt + 16'd1;
         end else if (drain) begin
            pix_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_gsn_mac_acc.sv
// Bench for gsn_mac_acc: directed vector table, multi-cycle corner sequences and
// a randomized phase scored against an arithmetic reference model.
module tb_gsn_mac_acc;
   localparam int NT = 25;
   localparam int SH = 8;
   localparam int NF = 40;

   logic        clk = 1'b0;
   logic        reset, ce, in_valid, in_ready, pix_valid, pix_ready;
   logic [21:0] prod;
   logic [7:0]  pix_out;
   logic [15:0] sat_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int sat_model = 0;
   int expq[$];
   int satq[$];

   typedef struct {
      int first;
      int rest;
      int exp_pix;
      int exp_sat;
   } vec_t;
   vec_t tbl[11];

   gsn_mac_acc #(.NUM_TAPS(NT), .SHIFT(SH)) dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .prod(prod),
      .in_ready(in_ready), .pix_out(pix_out), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .sat_cnt(sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sat_model = 0;
   endtask

   // Offers one product and returns 1 time unit after the edge that consumed it.
   task automatic push(input int v);
      int n = 0;
      prod = 22'(v);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_chk++; n_fail++;
         $display("FAIL push_timeout: got in_ready 0 expected 1 at %0t", $time);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic frame(input int first, input int rest);
      push(first);
      for (int i = 1; i < NT; i++) push(rest);
   endtask

   // Reference: plain integer round-half-up division by 2^SH, then clamp.
   function automatic int model(input longint sum, output bit sat);
      longint r;
      r = (sum + (longint'(1) << (SH - 1))) >>> SH;
      sat = (r < 0) || (r > 255);
      return (r < 0) ? 0 : ((r > 255) ? 255 : int'(r));
   endfunction

   initial begin
      int t[NT];
      longint sum;
      bit s;
      int ep;

      reset = 1'b1; ce = 1'b1; in_valid = 1'b0; prod = '0; pix_ready = 1'b1;
      tbl[0]  = '{25600, 0, 100, 0};
      tbl[1]  = '{383, 0, 1, 0};
      tbl[2]  = '{384, 0, 2, 0};
      tbl[3]  = '{127, 0, 0, 0};
      tbl[4]  = '{2097151, 2097151, 255, 1};
      tbl[5]  = '{-1000, 0, 0, 2};
      tbl[6]  = '{256, 256, 25, 2};
      tbl[7]  = '{-2097152, -2097152, 0, 3};
      tbl[8]  = '{65280, 0, 255, 3};
      tbl[9]  = '{65408, 0, 255, 4};
      tbl[10] = '{1, 1, 0, 4};

      do_reset();
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_out", pix_out, 0);
      check("rst_sat_cnt", sat_cnt, 0);
      check("rst_in_ready", in_ready, 1);

      for (int k = 0; k < 11; k++) begin
         frame(tbl[k].first, tbl[k].rest);
         check($sformatf("tbl%0d_valid", k), pix_valid, 1);
         check($sformatf("tbl%0d_pix", k), pix_out, tbl[k].exp_pix);
         check($sformatf("tbl%0d_sat", k), sat_cnt, tbl[k].exp_sat);
         @(posedge clk); #1;
         check($sformatf("tbl%0d_pulse", k), pix_valid, 0);
      end

      // Backpressure: last tap waits until the pending pixel drains.
      pix_ready = 1'b0;
      frame(256, 256);
      check("bp_pend_pix", pix_out, 25);
      push(25600);
      for (int i = 1; i < NT - 1; i++) push(0);
      prod = '0; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_stall_ready", in_ready, 0);
         check("bp_hold_pix", pix_out, 25);
         check("bp_hold_valid", pix_valid, 1);
      end
      @(posedge clk); #1 pix_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      check("bp_b2b_valid", pix_valid, 1);
      check("bp_b2b_pix", pix_out, 100);
      check("bp_sat", sat_cnt, 4);
      @(posedge clk); #1;
      check("bp_drained", pix_valid, 0);

      // Reset mid-frame discards partial sum.
      for (int i = 0; i < 10; i++) push(1000);
      do_reset();
      check("mid_rst_valid", pix_valid, 0);
      check("mid_rst_sat", sat_cnt, 0);
      check("mid_rst_ready", in_ready, 1);
      frame(256, 256);
      check("mid_rst_pix", pix_out, 25);
      check("mid_rst_sat2", sat_cnt, 0);
      @(posedge clk); #1;

      // Clock-enable gap mid-frame, then a frozen pending pixel.
      sum = 0;
      for (int i = 0; i < NT; i++) begin
         t[i] = (i * 37) % 500 - 100;
         sum += t[i];
      end
      ep = model(sum, s);
      for (int i = 0; i < 12; i++) push(t[i]);
      ce = 1'b0; in_valid = 1'b1; prod = 22'(t[12]);
      repeat (5) begin
         @(negedge clk);
         check("ce_gap_ready", in_ready, 0);
         check("ce_gap_valid", pix_valid, 0);
      end
      @(posedge clk); #1 ce = 1'b1; in_valid = 1'b0;
      for (int i = 12; i < NT; i++) push(t[i]);
      check("ce_gap_pix", pix_out, ep);
      check("ce_gap_pvalid", pix_valid, 1);
      ce = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("ce_freeze_valid", pix_valid, 1);
         check("ce_freeze_pix", pix_out, ep);
      end
      @(posedge clk); #1 ce = 1'b1;
      @(posedge clk); #1;
      check("ce_resume_drain", pix_valid, 0);

      // Randomized frames with random backpressure, input gaps and ce drops.
      do_reset();
      fork
         begin
            for (int f = 0; f < NF; f++) begin
               int mode = $urandom_range(0, 3);
               sum = 0;
               for (int i = 0; i < NT; i++) begin
                  int v = (mode == 0) ? int'($urandom_range(0, 4194303)) - 2097152
                                      : int'($urandom_range(0, 1600)) - 300;
                  if ($urandom_range(0, 7) == 0) begin
                     ce = 1'b0;
                     repeat ($urandom_range(1, 3)) @(posedge clk);
                     #1 ce = 1'b1;
                  end
                  if ($urandom_range(0, 5) == 0) begin
                     @(posedge clk); #1;
                  end
                  push(v);
                  sum += v;
               end
               ep = model(sum, s);
               if (s && sat_model < 65535) sat_model++;
               expq.push_back(ep);
               satq.push_back(sat_model);
            end
         end
         begin
            int got = 0;
            int cyc = 0;
            while (got < NF && cyc < 20000) begin
               @(posedge clk); #1 pix_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
               if (ce && pix_valid && pix_ready) begin
                  if (expq.size() == 0) begin
                     check("rnd_unexpected_pixel", 1, 0);
                  end else begin
                     check($sformatf("rnd%0d_pix", got), pix_out, expq.pop_front());
                     check($sformatf("rnd%0d_sat", got), sat_cnt, satq.pop_front());
                  end
                  got++;
               end
               cyc++;
            end
            check("rnd_pixels_seen", got, NF);
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
